// File: rtl/osc_mod_mixer_pkg.sv
// Shared constants for the two-oscillator modulation combiner: mode codes,
// FSM state encoding and a parameter sanity helper.
package osc_mod_pkg;

    localparam logic [2:0] MODE_AVG  = 3'd0;
    localparam logic [2:0] MODE_AM   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_SUM  = 3'd3;
    localparam logic [2:0] MODE_RING = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } osc_state_e;

    function automatic bit width_ok(input int w, input int o);
        return (w >= 2) && (o >= w) && (o <= 2 * w);
    endfunction

endpackage

// File: rtl/osc_mod_mixer_shift_add_mult.sv
// Iterative W-cycle shift-add multiplier; signed_en selects two's-complement
// operands (the top partial product is subtracted instead of added).
module shift_add_mult #(
    parameter int W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           sgn_q, sgn_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        sgn_d    = sgn_q;
        done     = busy_q && (cnt_q == CW'(W - 1));
        if (start) begin
            acc_d    = '0;
            mcand_d  = signed_en ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
            sgn_d    = signed_en;
        end else if (busy_q) begin
            // The multiplier MSB carries weight -2^(W-1) in signed mode.
            if (mplier_q[0])
                acc_d = (done && sgn_q) ? acc_q - mcand_q : acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            sgn_q    <= sgn_d;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/osc_mod_mixer.sv
// Two-oscillator modulation combiner (AVG/AM/XOR/SUM/RING), handshaked input,
// pulsed output. Define OSC_MOD_SAT_EN to make mode 3 saturate instead of wrap.
module osc_mod_mixer
    import osc_mod_pkg::*;
#(
    parameter int W = 12,
    parameter int O = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] osc_a,
    input  logic [W-1:0] osc_b,
    input  logic [2:0]   mode,
    output logic         out_valid,
    output logic [O-1:0] out_data
);

    if (!width_ok(W, O)) begin : g_cfg_err
        $error("osc_mod_mixer: illegal W/O combination");
    end

    osc_state_e     state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [O-1:0]   out_data_q, out_data_d;
    logic           ring_q, ring_d;

    logic           mul_start, mul_signed, mul_done;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;

    function automatic logic [O-1:0] left_justify(input logic [W-1:0] r);
        logic [O-1:0] t;
        t = '0;
        t[O-1 -: W] = r;
        return t;
    endfunction

    function automatic logic [O-1:0] comb_result(input logic [2:0] m,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [W:0]   s;
        logic [O-1:0] res;
        s   = {1'b0, a} + {1'b0, b};
        res = '0;
        case (m)
            MODE_AVG: res = left_justify(s[W:1]);
            MODE_XOR: res = left_justify(a ^ b);
`ifdef OSC_MOD_SAT_EN
            MODE_SUM: res = left_justify(s[W] ? '1 : s[W-1:0]);
`else
            MODE_SUM: res = left_justify(s[W-1:0]);
`endif
            default:  res = '0;
        endcase
        return res;
    endfunction

    // RING keeps one extra fraction bit; only (-2^(W-1))^2 overflows the sign.
    function automatic logic [O-1:0] fmt_product(input logic [2*W-1:0] p,
                                                 input logic ring);
        logic [O-1:0] r;
        if (!ring)
            return O'(p >> (2 * W - O));
        r = O'((p << 1) >> (2 * W - O));
        if (p[2*W-1:2*W-2] == 2'b01)
            r = {1'b0, {(O-1){1'b1}}};
        r[O-1] = ~r[O-1];
        return r;
    endfunction

    assign mul_signed = (mode == MODE_RING);
    assign mul_a      = mul_signed ? {~osc_a[W-1], osc_a[W-2:0]} : osc_a;
    assign mul_b      = mul_signed ? {~osc_b[W-1], osc_b[W-2:0]} : osc_b;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        ring_d      = ring_q;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (mode == MODE_AM || mode == MODE_RING) begin
                        mul_start  = 1'b1;
                        ring_d     = mul_signed;
                        in_ready_d = 1'b0;
                        state_d    = ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = comb_result(mode, osc_a, osc_b);
                    end
                end
            end
            ST_MUL: begin
                if (mul_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                out_data_d  = fmt_product(mul_p, ring_q);
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ring_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ring_q      <= ring_d;
        end
    end

    shift_add_mult #(.W(W)) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .signed_en (mul_signed),
        .a         (mul_a),
        .b         (mul_b),
        .done      (mul_done),
        .product   (mul_p)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_osc_mod_mixer.sv
// Directed bench for osc_mod_mixer at W=12, O=16 with hand-computed vectors.
module tb_osc_mod_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] osc_a = '0;
    logic [11:0] osc_b = '0;
    logic [2:0]  mode = '0;
    logic        out_valid;
    logic [15:0] out_data;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    osc_mod_mixer #(.W(12), .O(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .osc_a     (osc_a),
        .osc_b     (osc_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one transaction; returns 1 ns after the acceptance edge.
    task automatic accept(input logic [2:0] m, input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        osc_a    = a;
        osc_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [2:0] m,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [15:0] exp);
        accept(m, a, b);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
    endtask

    task automatic run_mul(input string tag, input logic [2:0] m,
                           input logic [11:0] a, input logic [11:0] b,
                           input logic [15:0] exp);
        int lat;
        int low;
        accept(m, a, b);
        lat = 0;
        low = in_ready ? 0 : 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!in_ready) low++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd13);
        check({tag, "_ready_low"}, 32'(low), 32'd13);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int pulses;
        logic [15:0] sum_ovf_exp;

        #12;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_single("avg", 3'd0, 12'hFFF, 12'h001, 16'h8000);
        @(posedge clk);
        #1;
        check("avg_pulse_end", 32'(out_valid), 32'd0);
        check("avg_hold", 32'(out_data), 32'h8000);

        run_mul("am_max", 3'd1, 12'hFFF, 12'hFFF, 16'hFFE0);
        run_mul("am_small", 3'd1, 12'h800, 12'h002, 16'h0010);
        run_mul("ring_clamp", 3'd4, 12'h000, 12'h000, 16'hFFFF);
        run_mul("ring_zero", 3'd4, 12'h800, 12'hFFF, 16'h8000);
        run_mul("ring_pos", 3'd4, 12'hC00, 12'hC00, 16'hA000);
        run_mul("ring_neg", 3'd4, 12'hC00, 12'h400, 16'h6000);

`ifdef OSC_MOD_SAT_EN
        sum_ovf_exp = 16'hFFF0;
`else
        sum_ovf_exp = 16'h0010;
`endif
        run_single("sum_ovf", 3'd3, 12'hFFF, 12'h002, sum_ovf_exp);
        run_single("sum_plain", 3'd3, 12'h123, 12'h456, 16'h5790);

        // Back-to-back XOR with in_valid held high.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 3'd2;
        osc_a    = 12'hAAA;
        osc_b    = 12'h555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("xor_b2b_valid", 32'(out_valid), 32'd1);
            check("xor_b2b_data", 32'(out_data), 32'hFFF0);
        end
        @(negedge clk);
        osc_a = 12'h0F0;
        osc_b = 12'h0FF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("xor_alt_data", 32'(out_data), 32'h00F0);

        // Multiply accepted, competing request held during MUL, then reset mid-MUL.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 3'd1;
        osc_a    = 12'hFFF;
        osc_b    = 12'hFFF;
        @(posedge clk);
        #1;
        mode  = 3'd2;
        osc_a = 12'hAAA;
        osc_b = 12'h555;
        check("busy_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("busy_no_valid", 32'(out_valid), 32'd0);
            check("busy_hold", 32'(out_data), 32'h00F0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_data_after", 32'(out_data), 32'd0);

        run_single("xor_pre", 3'd2, 12'hAAA, 12'h555, 16'hFFF0);
        run_single("mode6", 3'd6, 12'h123, 12'h456, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
